// File: rtl/sys_cmd_ctrl_if.sv
// Bus bundle between sys_cmd_ctrl and the RX / RegFile / ALU / UART_TX blocks.
// master = command controller, slave = surrounding subsystem.
interface sys_cmd_ctrl_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR       = 4,
  parameter int ALU_FUN_WD = 4
) ();
  logic [WIDTH-1:0]      RX_P_DATA;
  logic                  RX_D_VLD;
  logic                  WrEn;
  logic                  RdEn;
  logic [ADDR-1:0]       Address;
  logic [WIDTH-1:0]      WrData;
  logic [WIDTH-1:0]      RdData;
  logic                  RdData_VLD;
  logic                  ALU_EN;
  logic [ALU_FUN_WD-1:0] ALU_FUN;
  logic                  CLKG_EN;
  logic [WIDTH-1:0]      ALU_OUT;
  logic                  ALU_OUT_VLD;
  logic [WIDTH-1:0]      TX_P_DATA;
  logic                  TX_D_VLD;
  logic                  TX_BUSY;
  logic                  CMD_ERR;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RdData, RdData_VLD, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
    output WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLKG_EN, TX_P_DATA, TX_D_VLD, CMD_ERR
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RdData, RdData_VLD, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
    input  WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLKG_EN, TX_P_DATA, TX_D_VLD, CMD_ERR
  );
endinterface

// File: rtl/sys_cmd_ctrl.sv
// Byte-command sequencer owning the RegFile port, ALU enable/clock-gate and UART_TX hand-off.
// Optional watchdog on wait states: define SYS_CMD_CTRL_TIMEOUT_EN.
module sys_cmd_ctrl #(
  parameter int WIDTH       = 8,
  parameter int ADDR        = 4,
`ifdef SYS_CMD_CTRL_TIMEOUT_EN
  parameter int TIMEOUT_CYC = 255,
`endif
  parameter int ALU_FUN_WD  = 4
) (
  input  logic          CLK,
  input  logic          RST,
  sys_cmd_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B,
    ALU_FUN_S, ALU_WAIT, TX_SEND, TX_ACK
  } state_t;

  localparam logic [WIDTH-1:0] CMD_WR  = WIDTH'(8'hAA);
  localparam logic [WIDTH-1:0] CMD_RD  = WIDTH'(8'hBB);
  localparam logic [WIDTH-1:0] CMD_OP  = WIDTH'(8'hCC);
  localparam logic [WIDTH-1:0] CMD_NOP = WIDTH'(8'hDD);

  state_t                state_q, state_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  alu_en_q, alu_en_d;
  logic                  tx_vld_q, tx_vld_d;
  logic                  cmd_err_q, cmd_err_d;
  logic                  clkg_en_q, clkg_en_d;
  logic [ADDR-1:0]       addr_q, addr_d;
  logic [WIDTH-1:0]      wr_data_q, wr_data_d;
  logic [ALU_FUN_WD-1:0] alu_fun_q, alu_fun_d;
  logic [WIDTH-1:0]      result_q, result_d;
  logic [WIDTH-1:0]      tx_data_q, tx_data_d;

`ifdef SYS_CMD_CTRL_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) < 8) ? 8 : $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wd_cnt_q;
  logic             wait_st;

  assign wait_st = (state_q == RD_WAIT) || (state_q == ALU_WAIT) ||
                   (state_q == TX_SEND) || (state_q == TX_ACK);

  // Watchdog restarts whenever the FSM moves, so it measures time spent in one wait state.
  always_ff @(posedge CLK) begin
    if (RST || !wait_st || (state_d != state_q)) wd_cnt_q <= '0;
    else                                         wd_cnt_q <= wd_cnt_q + 1'b1;
  end
`endif

  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    alu_en_d  = 1'b0;
    tx_vld_d  = 1'b0;
    cmd_err_d = 1'b0;
    clkg_en_d = clkg_en_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    alu_fun_d = alu_fun_q;
    result_d  = result_q;
    tx_data_d = tx_data_q;

    unique case (state_q)
      IDLE: if (bus.RX_D_VLD) begin
        if      (bus.RX_P_DATA == CMD_WR)  state_d = WR_ADDR;
        else if (bus.RX_P_DATA == CMD_RD)  state_d = RD_ADDR;
        else if (bus.RX_P_DATA == CMD_OP)  state_d = OP_A;
        else if (bus.RX_P_DATA == CMD_NOP) state_d = ALU_FUN_S;
        else                               cmd_err_d = 1'b1;
      end
      WR_ADDR: if (bus.RX_D_VLD) begin
        addr_d  = bus.RX_P_DATA[ADDR-1:0];
        state_d = WR_DATA;
      end
      WR_DATA: if (bus.RX_D_VLD) begin
        wr_en_d   = 1'b1;
        wr_data_d = bus.RX_P_DATA;
        state_d   = IDLE;
      end
      RD_ADDR: if (bus.RX_D_VLD) begin
        rd_en_d = 1'b1;
        addr_d  = bus.RX_P_DATA[ADDR-1:0];
        state_d = RD_WAIT;
      end
      RD_WAIT: if (bus.RdData_VLD) begin
        result_d = bus.RdData;
        state_d  = TX_SEND;
      end
      // Operands land in registers 0/1, where the ALU reads them directly.
      OP_A: if (bus.RX_D_VLD) begin
        wr_en_d   = 1'b1;
        addr_d    = '0;
        wr_data_d = bus.RX_P_DATA;
        state_d   = OP_B;
      end
      OP_B: if (bus.RX_D_VLD) begin
        wr_en_d   = 1'b1;
        addr_d    = ADDR'(1);
        wr_data_d = bus.RX_P_DATA;
        state_d   = ALU_FUN_S;
      end
      ALU_FUN_S: if (bus.RX_D_VLD) begin
        alu_en_d  = 1'b1;
        clkg_en_d = 1'b1;
        alu_fun_d = bus.RX_P_DATA[ALU_FUN_WD-1:0];
        state_d   = ALU_WAIT;
      end
      ALU_WAIT: if (bus.ALU_OUT_VLD) begin
        result_d  = bus.ALU_OUT;
        clkg_en_d = 1'b0;
        state_d   = TX_SEND;
      end
      TX_SEND: if (!bus.TX_BUSY) begin
        tx_vld_d  = 1'b1;
        tx_data_d = result_q;
        state_d   = TX_ACK;
      end
      TX_ACK: if (bus.TX_BUSY) state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef SYS_CMD_CTRL_TIMEOUT_EN
    if (wait_st && (state_d == state_q) && (wd_cnt_q == CNT_W'(TIMEOUT_CYC - 1))) begin
      cmd_err_d = 1'b1;
      clkg_en_d = 1'b0;
      state_d   = IDLE;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      alu_en_q  <= 1'b0;
      tx_vld_q  <= 1'b0;
      cmd_err_q <= 1'b0;
      clkg_en_q <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      alu_fun_q <= '0;
      result_q  <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      alu_en_q  <= alu_en_d;
      tx_vld_q  <= tx_vld_d;
      cmd_err_q <= cmd_err_d;
      clkg_en_q <= clkg_en_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      alu_fun_q <= alu_fun_d;
      result_q  <= result_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign bus.WrEn      = wr_en_q;
  assign bus.RdEn      = rd_en_q;
  assign bus.ALU_EN    = alu_en_q;
  assign bus.TX_D_VLD  = tx_vld_q;
  assign bus.CMD_ERR   = cmd_err_q;
  assign bus.CLKG_EN   = clkg_en_q;
  assign bus.Address   = addr_q;
  assign bus.WrData    = wr_data_q;
  assign bus.ALU_FUN   = alu_fun_q;
  assign bus.TX_P_DATA = tx_data_q;

endmodule
